imm_decode_stage: RTL and testbench
===================================

Name: imm_decode_stage

Overview:
- Decode-side front end for the immediate datapath of the 64-bit RISC-V core.
- Accepts fetched instructions over a valid/ready handshake and decodes the opcode into the signExtend `sel_type`.
- Drives an internal signExtend instance and buffers the instruction, PC, immediate and decode flags in a small FIFO.
- Presents the buffered result to the execute stage over a second valid/ready handshake, with flush support.

Parameters:
- DEPTH, 2, number of buffer entries; legal values are 2, 4 and 8.
- XLEN, 64, width of PC and immediate.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous flush; discards all buffered entries.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  block can accept an instruction.
- in_instr  in  32  fetched instruction.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  downstream accepts the head entry.
- out_instr  out  32  head instruction.
- out_pc  out  XLEN  head PC.
- out_imm  out  XLEN  head immediate.
- out_sel_type  out  3  sel_type used for the head entry.
- out_illegal  out  1  head opcode is unrecognised.

Behaviour:
- Reset (async, rst=1): count=0, rd_ptr=0, wr_ptr=0.
  - Outputs: in_ready=0 while rst is high, then 1; out_valid=0; out_instr=0; out_pc=0; out_imm=0; out_sel_type=5; out_illegal=0.
- Enqueue when in_valid && in_ready. Dequeue when out_valid && out_ready.
- in_ready = (count != DEPTH). It depends only on registered state, never combinationally on out_ready.
- out_valid = (count != 0). The out_* data are read from the entry at rd_ptr.
- Decode is combinational on in_instr at enqueue time, and the result is stored in the entry. Opcode (instr[6:0]) to sel_type:
  - 0000011, 0010011, 0011011, 1100111, 1110011 -> 0 (I).
  - 0100011 -> 1 (S).
  - 1100011 -> 2 (SB).
  - 0110111, 0010111 -> 3 (U).
  - 1101111 -> 4 (UJ).
  - 0110011, 0111011 -> 5 (none).
  - Any other opcode -> 5 with illegal=1.
- For sel_type 5 the stored imm is forced to 0. Otherwise the stored imm is the signExtend `extension` output.
- All immediates are sign-extended to XLEN. U-type is imm[31:12]<<12, then sign-extended from bit 31.
- Latency: an instruction accepted in cycle N is visible with out_valid=1 in cycle N+1. With out_ready held high, throughput is 1 per cycle.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- When full, in_ready=0 and in_valid is ignored. A dequeue in that cycle raises in_ready in the next cycle, not the same one.
- When empty, out_valid=0 and out_ready is ignored.
- Pointers wrap modulo DEPTH.
- flush=1: next cycle count=0, rd_ptr=wr_ptr=0.
  - Flush overrides any same-cycle enqueue or dequeue; that input is dropped and the dequeue is not counted.
- Reset asserted mid-operation clears all state immediately; in-flight entries are lost.
- Stored entry data need not be reset; only the out_* values observed while count=0 are defined, as listed above.
- out_* data must be stable while out_valid && !out_ready.

Optional Feature:
- Macro: IMM_DECODE_STATS_EN.
- When defined:
  - Adds output illegal_count (16 bits), counting dequeued entries with illegal=1.
  - Saturates at 0xFFFF.
  - Cleared by rst; not cleared by flush.
- When undefined: the port and counter are absent, and the rest of the behaviour is identical.

Decomposition:
- Package imm_decode_pkg holds:
  - the sel_type enum (SEL_I=0, SEL_S=1, SEL_SB=2, SEL_U=3, SEL_UJ=4, SEL_NONE=5);
  - opcode localparams;
  - the entry struct {instr, pc, imm, sel, illegal};
  - the function opcode_to_sel().
- Sub-module: the existing signExtend, instantiated once on the enqueue path.
- The FIFO storage stays inline; no separate FIFO module.

Test Plan:
- Reset: rst=1, then 0 -> out_valid=0, in_ready=1, out_sel_type=5.
- addi 0xFFF00093, pc=0x100 -> next cycle out_valid=1, out_sel_type=0, out_imm=0xFFFFFFFFFFFFFFFF, out_pc=0x100, out_illegal=0.
- lui 0x800000B7, then add 0x00000033 -> first entry: sel=3, imm=0xFFFFFFFF80000000. Second entry: sel=5, imm=0.
- Backpressure, DEPTH=2, out_ready=0, push 3 instructions -> in_ready=0 after 2 accepted, the third is held upstream. Raise out_ready -> outputs appear in order with no loss or duplication.
- Illegal 0x0000007F -> sel=5, imm=0, out_illegal=1. Under IMM_DECODE_STATS_EN, illegal_count=1 after dequeue.
- With 2 entries buffered, pulse flush together with in_valid=1 -> next cycle out_valid=0, count=0, and the flush-cycle instruction is not stored.

Source files
------------

// File: rtl/imm_decode_pkg.sv
// Shared decode types for the immediate datapath: sel_type encoding,
// RV64 major opcodes, buffered entry layout and the opcode decoder.
package imm_decode_pkg;

  localparam int unsigned XLEN_MAX = 64;

  typedef enum logic [2:0] {
    SEL_I    = 3'd0,
    SEL_S    = 3'd1,
    SEL_SB   = 3'd2,
    SEL_U    = 3'd3,
    SEL_UJ   = 3'd4,
    SEL_NONE = 3'd5
  } sel_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  // Fields are sized for the widest core; narrower builds use the low bits.
  typedef struct packed {
    logic [31:0]         instr;
    logic [XLEN_MAX-1:0] pc;
    logic [XLEN_MAX-1:0] imm;
    sel_t                sel;
    logic                illegal;
  } entry_t;

  typedef struct packed {
    sel_t sel;
    logic illegal;
  } decode_t;

  function automatic decode_t opcode_to_sel(input logic [6:0] opcode);
    decode_t d;
    d.sel     = SEL_NONE;
    d.illegal = 1'b0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM: d.sel = SEL_I;
      OP_STORE:                                      d.sel = SEL_S;
      OP_BRANCH:                                     d.sel = SEL_SB;
      OP_LUI, OP_AUIPC:                              d.sel = SEL_U;
      OP_JAL:                                        d.sel = SEL_UJ;
      OP_OP, OP_OP32:                                d.sel = SEL_NONE;
      default:                                       d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/imm_decode_stage_sign_extend.sv
// signExtend: assembles the RISC-V immediate selected by sel_type and
// sign-extends it to XLEN (XLEN >= 32).
module signExtend
  import imm_decode_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]     instr,
  input  sel_t            sel_type,
  output logic [XLEN-1:0] extension
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (sel_type)
      SEL_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      SEL_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      SEL_SB:  imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
      SEL_U:   imm32 = {instr[31:12], 12'b0};
      SEL_UJ:  imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign extension = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_decode_stage.sv
// Decode front end: decodes opcode/immediate at enqueue and buffers the result
// in a DEPTH-entry FIFO. Optional IMM_DECODE_STATS_EN adds illegal_count.
module imm_decode_stage
  import imm_decode_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_sel_type,
  output logic            out_illegal
`ifdef IMM_DECODE_STATS_EN
  ,
  output logic [15:0]     illegal_count
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  entry_t           mem_q [DEPTH];

  decode_t          dec;
  logic [XLEN-1:0]  ext;
  entry_t           wr_entry;
  entry_t           head;
  logic             full, empty, enq, deq;

  assign dec = opcode_to_sel(in_instr[6:0]);

  signExtend #(.XLEN(XLEN)) u_sign_extend (
    .instr     (in_instr),
    .sel_type  (dec.sel),
    .extension (ext)
  );

  always_comb begin
    wr_entry         = '0;
    wr_entry.instr   = in_instr;
    wr_entry.pc      = XLEN_MAX'(in_pc);
    wr_entry.imm     = (dec.sel == SEL_NONE) ? '0 : XLEN_MAX'(ext);
    wr_entry.sel     = dec.sel;
    wr_entry.illegal = dec.illegal;
  end

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);

  assign in_ready  = !rst && !full;
  assign out_valid = !empty;
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is deliberately unreset; outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (enq && !flush) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign head = mem_q[rd_ptr_q];

  assign out_instr    = empty ? '0 : head.instr;
  assign out_pc       = empty ? '0 : head.pc[XLEN-1:0];
  assign out_imm      = empty ? '0 : head.imm[XLEN-1:0];
  assign out_sel_type = empty ? SEL_NONE : head.sel;
  assign out_illegal  = empty ? 1'b0 : head.illegal;

`ifdef IMM_DECODE_STATS_EN
  logic [15:0] illegal_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_cnt_q <= '0;
    end else if (deq && !flush && head.illegal && (illegal_cnt_q != '1)) begin
      illegal_cnt_q <= illegal_cnt_q + 16'd1;
    end
  end

  assign illegal_count = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench for imm_decode_stage: driver pushes expected entries,
// a negedge monitor pops and compares on every output handshake.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [63:0] out_imm;
  logic [2:0]  out_sel_type;
  logic        out_illegal;
`ifdef IMM_DECODE_STATS_EN
  logic [15:0] illegal_count;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [2:0]  sel;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  imm_decode_stage #(.DEPTH(2), .XLEN(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_imm      (out_imm),
    .out_sel_type (out_sel_type),
    .out_illegal  (out_illegal)
`ifdef IMM_DECODE_STATS_EN
    ,
    .illegal_count(illegal_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; holds in_valid until the DUT accepts.
  task automatic push(input logic [31:0] ins, input logic [63:0] pc,
                      input logic [2:0] sel, input logic [63:0] imm, input logic ill);
    int unsigned t = 0;
    bit done = 1'b0;
    exp_t e;
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        e.instr = ins; e.pc = pc; e.imm = imm; e.sel = sel; e.ill = ill;
        exp_q.push_back(e);
        done = 1'b1;
      end else if (++t > 50) begin
        n_assert++;
        n_fail++;
        $display("FAIL push_timeout: got in_ready=0 expected accept of 0x%0h", ins);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int unsigned t = 0;
    while (out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("drain", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_output: got instr 0x%0h expected none", out_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_instr",    {32'd0, out_instr},    {32'd0, e.instr});
        chk("out_pc",       out_pc,                e.pc);
        chk("out_imm",      out_imm,               e.imm);
        chk("out_sel_type", {61'd0, out_sel_type}, {61'd0, e.sel});
        chk("out_illegal",  {63'd0, out_illegal},  {63'd0, e.ill});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_out_valid", {63'd0, out_valid}, 64'd0);
    chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
    chk("idle_sel_type", {61'd0, out_sel_type}, 64'd5);
    chk("idle_out_imm", out_imm, 64'd0);
    chk("idle_out_pc", out_pc, 64'd0);
    chk("idle_out_instr", {32'd0, out_instr}, 64'd0);
    chk("idle_out_illegal", {63'd0, out_illegal}, 64'd0);
    @(posedge clk); #1;

    // addi and one-cycle latency
    out_ready = 1'b1;
    push(32'hFFF00093, 64'h100, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    @(negedge clk);
    chk("latency_out_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    wait_empty();

    // back-to-back stream covering every immediate format
    push(32'h800000B7, 64'h104, 3'd3, 64'hFFFFFFFF80000000, 1'b0);
    push(32'h00000033, 64'h108, 3'd5, 64'h0, 1'b0);
    push(32'hFE112E23, 64'h10C, 3'd1, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    push(32'h00000463, 64'h110, 3'd2, 64'h8, 1'b0);
    push(32'hFFFFF06F, 64'h114, 3'd4, 64'hFFFFFFFFFFFFFFFE, 1'b0);
    push(32'h12345017, 64'h118, 3'd3, 64'h12345000, 1'b0);
    push(32'h7FF0B083, 64'h11C, 3'd0, 64'h7FF, 1'b0);
    push(32'h0000007F, 64'h120, 3'd5, 64'h0, 1'b1);
    wait_empty();

    // backpressure: two fill the buffer, the third waits upstream
    out_ready = 1'b0;
    push(32'h00100093, 64'h200, 3'd0, 64'h1, 1'b0);
    push(32'h00200113, 64'h204, 3'd0, 64'h2, 1'b0);
    @(negedge clk);
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    chk("full_out_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    fork
      push(32'h00300193, 64'h208, 3'd0, 64'h3, 1'b0);
      begin
        repeat (3) @(negedge clk);
        chk("held_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        #1;
        chk("ready_not_comb", {63'd0, in_ready}, 64'd0);
      end
    join
    wait_empty();

    // flush with a full buffer and a concurrent in_valid
    out_ready = 1'b0;
    push(32'h0000007F, 64'h300, 3'd5, 64'h0, 1'b1);
    push(32'h00400213, 64'h304, 3'd0, 64'h4, 1'b0);
    in_valid = 1'b1; in_instr = 32'h00500293; in_pc = 64'h308; flush = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    chk("flush_sel_type", {61'd0, out_sel_type}, 64'd5);
    @(posedge clk); #1;

    // flush with one entry while the input is acceptable: that input is dropped
    push(32'h00600313, 64'h400, 3'd0, 64'h6, 1'b0);
    in_valid = 1'b1; in_instr = 32'h00700393; in_pc = 64'h404; flush = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush2_out_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk("flush2_stays_empty", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;

    // pointers restart at zero after flush
    out_ready = 1'b1;
    push(32'h80000437, 64'h500, 3'd3, 64'hFFFFFFFF80000000, 1'b0);
    push(32'hFFF00493, 64'h504, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    wait_empty();

`ifdef IMM_DECODE_STATS_EN
    chk("illegal_count", {48'd0, illegal_count}, 64'd1);
`endif
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
